// File: rtl/uart_msg_sched.sv
// uart_msg_sched: round-robin arbiter that shares one byte-wide UART
// transmitter between two 4-character message sources. An accepted message
// goes out as its 4 characters, most significant byte first, followed by a
// terminator byte. A fixed idle gap follows before the next grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no message owned; arbitrate between pending sources
// SEND  | presenting bytes 0..3 of the message, then TERM, to the UART
// GAP   | terminator accepted; counting down the idle gap before IDLE

module uart_msg_sched #(
    parameter logic [7:0]  TERM       = 8'h0A,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] msg_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

    state_t      state, state_n;
    logic [31:0] shreg, shreg_n;       // current character always in [31:24]
    logic [2:0]  byte_idx, byte_idx_n; // 0..3 characters, 4 = terminator
    logic [15:0] gap_cnt, gap_cnt_n;
    logic        rr_prio, rr_prio_n;   // source that wins the next tie
    logic        grant_id_n;
    logic        rdy0_n, rdy1_n;
    logic [15:0] msg_count_n;
    logic        take0, take1;
    logic        last_byte;

    assign last_byte = (byte_idx == 3'd4);

    // Transmit side is a pure decode of the held state, so it cannot change
    // while the transmitter is stalling.
    assign tx_valid = (state == SEND);
    assign tx_data  = (state != SEND) ? 8'h00 :
                      last_byte       ? TERM  : shreg[31:24];
    assign busy     = (state != IDLE);

    // State and datapath registers; reset aborts any message in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= 32'h0;
            byte_idx   <= 3'd0;
            gap_cnt    <= 16'h0;
            rr_prio    <= 1'b0;
            grant_id   <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            msg_count  <= 16'h0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            byte_idx   <= byte_idx_n;
            gap_cnt    <= gap_cnt_n;
            rr_prio    <= rr_prio_n;
            grant_id   <= grant_id_n;
            req0_ready <= rdy0_n;
            req1_ready <= rdy1_n;
            msg_count  <= msg_count_n;
        end
    end

    // Next-state logic: arbitration in IDLE, byte stepping in SEND, gap countdown.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        byte_idx_n  = byte_idx;
        gap_cnt_n   = gap_cnt;
        rr_prio_n   = rr_prio;
        grant_id_n  = grant_id;
        rdy0_n      = 1'b0;
        rdy1_n      = 1'b0;
        msg_count_n = msg_count;
        take0       = 1'b0;
        take1       = 1'b0;

        case (state)
            IDLE: begin
                take0 = req0_valid && (!req1_valid || (rr_prio == 1'b0));
                take1 = req1_valid && !take0;
                if (take0 || take1) begin
                    rdy0_n     = take0;
                    rdy1_n     = take1;
                    shreg_n    = take0 ? req0_data : req1_data;
                    grant_id_n = take1;
                    // The winner loses the next tie.
                    rr_prio_n  = take0;
                    byte_idx_n = 3'd0;
                    state_n    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (last_byte) begin
                        msg_count_n = msg_count + 16'd1;
                        byte_idx_n  = 3'd0;
                        if (GAP_LOAD == 16'd0) begin
                            state_n = IDLE;
                        end else begin
                            gap_cnt_n = GAP_LOAD;
                            state_n   = GAP;
                        end
                    end else begin
                        byte_idx_n = byte_idx + 3'd1;
                        shreg_n    = {shreg[23:0], 8'h00};
                    end
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt - 16'd1;
                if (gap_cnt <= 16'd1) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_msg_sched.sv
// Bench for uart_msg_sched: directed phases plus a randomized phase, checked
// cycle by cycle against a message-level model (expected byte queue, gap
// countdown, round-robin rule) and a receiver that rebuilds text lines.
module tb_uart_msg_sched;

    localparam int GAP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, grant_id;
    logic [15:0] msg_count;

    logic        z_v0, z_v1, z_r0, z_r1, z_txv, z_txr, z_busy, z_gid;
    logic [31:0] z_d0, z_d1;
    logic [7:0]  z_txd;
    logic [15:0] z_cnt;

    uart_msg_sched #(.TERM(8'h0A), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id), .msg_count(msg_count)
    );

    uart_msg_sched #(.TERM(8'h0A), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req0_valid(z_v0), .req0_data(z_d0), .req0_ready(z_r0),
        .req1_valid(z_v1), .req1_data(z_d1), .req1_ready(z_r1),
        .tx_data(z_txd), .tx_valid(z_txv), .tx_ready(z_txr),
        .busy(z_busy), .grant_id(z_gid), .msg_count(z_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // model state
    logic [7:0]  exp_q[$];
    int          gap_left;
    logic [15:0] m_count;
    logic        m_gid, m_prio, pend_g;
    logic        pv0, pv1;
    logic [31:0] pd0, pd1;
    // receiver
    string       rx_cur;
    string       rx_lines[$];
    int          xfers;
    // sources
    bit          offer0, offer1, acc0, acc1, fix_en, withdraw_en;
    int          left0, left1, tx_mode, cyc_n;
    logic [31:0] fix0, fix1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input string exp);
        string got;
        got = "<none>";
        if (rx_lines.size() > 0) got = rx_lines.pop_front();
        $display("uart rx: %s", got);
        n_chk++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_valid"},  32'(tx_valid),   32'd0);
        chk({tag, "_tx_data"},   32'(tx_data),    32'd0);
        chk({tag, "_req0_rdy"},  32'(req0_ready), 32'd0);
        chk({tag, "_req1_rdy"},  32'(req1_ready), 32'd0);
        chk({tag, "_busy"},      32'(busy),       32'd0);
        chk({tag, "_grant_id"},  32'(grant_id),   32'd0);
        chk({tag, "_msg_count"}, 32'(msg_count),  32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        gap_left = 0;
        m_count  = 16'd0;
        m_gid    = 1'b0;
        m_prio   = 1'b0;
        pend_g   = 1'b0;
        pv0 = 1'b0; pv1 = 1'b0; pd0 = 32'h0; pd1 = 32'h0;
        rx_cur   = "";
    endtask

    // Called at the falling edge: compares this cycle's outputs with the
    // model, then advances the model to the next cycle.
    task automatic monitor();
        logic        exp_id, exp_busy, next_pend, term;
        logic [31:0] d;
        cyc_n++;
        if (rst) begin
            model_reset();
            return;
        end
        if (tx_valid && tx_ready) begin
            xfers++;
            if (tx_data == 8'h0A) begin
                rx_lines.push_back(rx_cur);
                rx_cur = "";
            end else begin
                rx_cur = $sformatf("%s%c", rx_cur, tx_data);
            end
        end
        chk("ready_when_due", 32'(req0_ready | req1_ready), 32'(pend_g));
        chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        if (req0_ready) acc0 = 1'b1;
        if (req1_ready) acc1 = 1'b1;
        if (pend_g) begin
            exp_id = (pv0 && pv1) ? m_prio : !pv0;
            chk("grant_src", 32'(req1_ready), 32'(exp_id));
            d = exp_id ? pd1 : pd0;
            exp_q.push_back(d[31:24]);
            exp_q.push_back(d[23:16]);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
            exp_q.push_back(8'h0A);
            m_gid  = exp_id;
            m_prio = !exp_id;
        end
        exp_busy = (exp_q.size() != 0) || (gap_left > 0);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("msg_count", 32'(msg_count), 32'(m_count));
        if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
        next_pend = !exp_busy && (req0_valid || req1_valid);
        term = 1'b0;
        if (exp_q.size() != 0 && tx_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                term    = 1'b1;
                m_count = m_count + 16'd1;
            end
        end
        if (term) gap_left = GAP;
        else if (gap_left > 0) gap_left--;
        pend_g = next_pend;
        pv0 = req0_valid; pv1 = req1_valid;
        pd0 = req0_data;  pd1 = req1_data;
    endtask

    task automatic drive();
        if (acc0) begin acc0 = 1'b0; offer0 = 1'b0; end
        if (acc1) begin acc1 = 1'b0; offer1 = 1'b0; end
        if (withdraw_en && offer0 && busy && ($urandom % 8 == 0)) offer0 = 1'b0;
        if (withdraw_en && offer1 && busy && ($urandom % 8 == 0)) offer1 = 1'b0;
        if (!offer0 && left0 > 0 && (fix_en || ($urandom % 3 == 0))) begin
            offer0 = 1'b1; left0--;
            req0_data = fix_en ? fix0 : $urandom;
        end
        if (!offer1 && left1 > 0 && (fix_en || ($urandom % 3 == 0))) begin
            offer1 = 1'b1; left1--;
            req1_data = fix_en ? fix1 : $urandom;
        end
        req0_valid = offer0;
        req1_valid = offer1;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc_n % 4 == 0);
            default: tx_ready = 1'($urandom % 2);
        endcase
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < bound) begin
            cyc();
            n++;
            done = (left0 == 0) && (left1 == 0) && !offer0 && !offer1 &&
                   (exp_q.size() == 0) && (gap_left == 0) && !pend_g;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic interrupt_src0(input logic [31:0] d);
        int guard;
        guard = 0;
        fix_en = 1'b1; fix0 = d; left0 = 1; tx_mode = 0; xfers = 0;
        while (xfers < 2 && guard < 50) begin
            cyc();
            guard++;
        end
        chk("abort_point", 32'(xfers), 32'd2);
        #2 rst = 1'b1;
        #1 check_zero("abort");
        offer0 = 1'b0; left0 = 0; req0_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int zc, last_term, grants, zx, terms;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 32'h0; req1_data = 32'h0;
        tx_ready = 1'b0;
        z_v0 = 1'b0; z_v1 = 1'b0; z_d0 = 32'h0; z_d1 = 32'h0; z_txr = 1'b0;
        offer0 = 0; offer1 = 0; acc0 = 0; acc1 = 0; fix_en = 1; withdraw_en = 0;
        left0 = 0; left1 = 0; tx_mode = 0; cyc_n = 0; xfers = 0;
        fix0 = 32'h0; fix1 = 32'h0;
        model_reset();

        // asynchronous reset, before any clock edge
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) cyc();

        // single message, transmitter always ready
        fix0 = 32'h48454C4C; left0 = 1; tx_mode = 0;
        run_until_idle(100, "hell_done");
        chk_line("hell_line", "HELL");
        chk("hell_count", 32'(msg_count), 32'd1);

        // backpressure: one ready cycle in four
        rx_lines.delete(); xfers = 0;
        fix1 = 32'h574F524C; left1 = 1; tx_mode = 1;
        run_until_idle(200, "bp_done");
        chk("bp_xfers", 32'(xfers), 32'd5);
        chk_line("bp_line", "WORL");

        // arbitration with both sources continuously valid
        pulse_rst();
        rx_lines.delete();
        fix0 = 32'h41414141; fix1 = 32'h42424242; left0 = 2; left1 = 2; tx_mode = 0;
        run_until_idle(300, "arb_done");
        chk_line("arb_line0", "AAAA");
        chk_line("arb_line1", "BBBB");
        chk_line("arb_line2", "AAAA");
        chk_line("arb_line3", "BBBB");
        chk("arb_count", 32'(msg_count), 32'd4);

        // reset mid-message, then source 1 alone
        interrupt_src0(32'h43444546);
        rx_lines.delete();
        fix1 = 32'h31323334; left1 = 1;
        run_until_idle(100, "abort_src1_done");
        chk_line("abort_src1_line", "1234");
        chk("abort_src1_count", 32'(msg_count), 32'd1);
        chk("abort_no_extra_line", 32'(rx_lines.size()), 32'd0);

        // reset mid-message from source 0; the pointer must favour source 0 again
        interrupt_src0(32'h43444546);
        rx_lines.delete();
        fix0 = 32'h35363738; fix1 = 32'h31323334; left0 = 1; left1 = 1;
        run_until_idle(100, "rr_reset_done");
        chk_line("rr_reset_first", "5678");
        chk_line("rr_reset_second", "1234");

        // randomized traffic, stalls and withdrawn requests
        fix_en = 1'b0; withdraw_en = 1'b1; tx_mode = 2; left0 = 20; left1 = 20;
        run_until_idle(5000, "rand_done");
        withdraw_en = 1'b0;

        // zero-gap instance: back-to-back grants one cycle after each terminator
        z_d0 = 32'h30303030; z_d1 = 32'h31313131; z_txr = 1'b1;
        z_v0 = 1'b1; z_v1 = 1'b1;
        last_term = -1; grants = 0; zx = 0; terms = 0;
        for (zc = 0; zc < 40; zc++) begin
            @(negedge clk);
            if (z_r0 || z_r1) begin
                chk("z_grant_src", 32'(z_r1), 32'(grants % 2));
                if (last_term >= 0) chk("z_regrant_latency", 32'(zc - last_term), 32'd2);
                grants++;
            end
            if (last_term >= 0 && zc == last_term + 1) chk("z_idle_busy", 32'(z_busy), 32'd0);
            if (z_txv && z_txr) begin
                zx++;
                if (zx % 5 == 0) begin
                    chk("z_term_byte", 32'(z_txd), 32'h0A);
                    last_term = zc;
                    terms++;
                end
            end
        end
        z_v0 = 1'b0; z_v1 = 1'b0;
        for (zc = 0; zc < 12; zc++) begin
            @(negedge clk);
            if (z_txv && z_txr) begin
                zx++;
                if (zx % 5 == 0) terms++;
            end
        end
        @(negedge clk);
        chk("z_msg_count", 32'(z_cnt), 32'(terms));
        chk("z_grants_seen", 32'(grants >= 6), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
